// File: rtl/fir4_rr_sched.sv
// fir4_rr_sched: round-robin scheduler sharing one 4-tap averaging FIR.
// Each channel keeps a 3-sample tap history; one channel is granted per
// cycle and its sum x+h0+h1+h2 is registered with the channel tag.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   en                 global enable (0 = no grants)
//   in_valid/in_ready  per-channel handshake, in_ready is one-hot or 0
//   in_data            packed samples, ch i = in_data[i*W +: W]
//   clr_ch             per-channel history clear
//   out_valid/ready    output handshake
//   out_ch/sum/avg     channel tag, exact W+2 bit sum, floor(sum/4)
module fir4_rr_sched #(
    parameter int W   = 16,
    parameter int NCH = 4,
    localparam int CW = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH*W-1:0] in_data,
    output logic [NCH-1:0]   in_ready,
    input  logic [NCH-1:0]   clr_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_ch,
    output logic [W+1:0]     out_sum,
    output logic [W-1:0]     out_avg
);

    logic [W-1:0]   din [NCH];
    logic [W-1:0]   h0  [NCH];
    logic [W-1:0]   h1  [NCH];
    logic [W-1:0]   h2  [NCH];

    logic [CW-1:0]  rr_ptr;
    logic [CW-1:0]  gnt;
    logic [CW-1:0]  cand;
    logic           gnt_any;
    logic           slot_free;
    logic           accept;

    logic [W-1:0]   x;
    logic [W-1:0]   t0;
    logic [W-1:0]   t1;
    logic [W-1:0]   t2;
    logic [W+1:0]   sum_nxt;

    for (genvar i = 0; i < NCH; i++) begin : g_din
        assign din[i] = in_data[i*W +: W];
    end

    // Search starts just after the last granted channel.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = CW'((int'(rr_ptr) + k) % NCH);
            if (!gnt_any && in_valid[cand]) begin
                gnt     = cand;
                gnt_any = 1'b1;
            end
        end
    end

    assign slot_free = ~out_valid | out_ready;

    // Gated by rst_n so no handshake completes while reset is held.
    assign accept = rst_n & en & slot_free & gnt_any;

    always_comb begin
        in_ready = '0;
        if (accept) begin
            in_ready[gnt] = 1'b1;
        end
    end

    // A clear in the same cycle means the sample sees zero history.
    always_comb begin
        x  = din[gnt];
        t0 = clr_ch[gnt] ? '0 : h0[gnt];
        t1 = clr_ch[gnt] ? '0 : h1[gnt];
        t2 = clr_ch[gnt] ? '0 : h2[gnt];
        sum_nxt = {2'b00, x}  + {2'b00, t0}
                + {2'b00, t1} + {2'b00, t2};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                h0[i] <= '0;
                h1[i] <= '0;
                h2[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (accept && gnt == CW'(i)) begin
                    h0[i] <= x;
                    h1[i] <= clr_ch[i] ? '0 : h0[i];
                    h2[i] <= clr_ch[i] ? '0 : h1[i];
                end else if (clr_ch[i]) begin
                    h0[i] <= '0;
                    h1[i] <= '0;
                    h2[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= CW'(NCH - 1);
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_sum   <= '0;
        end else if (accept) begin
            rr_ptr    <= gnt;
            out_valid <= 1'b1;
            out_ch    <= gnt;
            out_sum   <= sum_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_avg = out_sum[W+1:2];

endmodule

// File: tb/tb_fir4_rr_sched.sv
// tb_fir4_rr_sched: randomized and directed bench for fir4_rr_sched
// against a queue-based reference model of the channel histories.
module tb_fir4_rr_sched;

    localparam int W   = 16;
    localparam int NCH = 4;
    localparam int CW  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b1;
    logic [NCH-1:0]   in_valid = '0;
    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_ready;
    logic [NCH-1:0]   clr_ch = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [CW-1:0]    out_ch;
    logic [W+1:0]     out_sum;
    logic [W-1:0]     out_avg;

    logic [W-1:0]     d [NCH];

    int checks = 0;
    int failures = 0;

    // Reference model: per-channel list of past samples, newest first.
    int hq [NCH][$];
    int m_last;
    bit m_ov;
    int m_och;
    int m_osum;

    fir4_rr_sched #(.W(W), .NCH(NCH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .clr_ch    (clr_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_sum   (out_sum),
        .out_avg   (out_avg)
    );

    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int i = 0; i < NCH; i++) begin
            in_data[i*W +: W] = d[i];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) hq[i].delete();
        m_last = NCH - 1;
        m_ov   = 1'b0;
        m_och  = 0;
        m_osum = 0;
    endtask

    // One clock: check in_ready before the edge, outputs just after it.
    task automatic cycle(output int g);
        int eg;
        int c;
        int s;
        logic [NCH-1:0] er;
        logic [W+1:0] es;
        @(negedge clk);
        eg = -1;
        if (en && (!m_ov || out_ready)) begin
            for (int k = 1; k <= NCH; k++) begin
                c = (m_last + k) % NCH;
                if (eg < 0 && ((in_valid >> c) & 1) != 0) eg = c;
            end
        end
        er = (eg >= 0) ? (NCH'(1) << eg) : '0;
        checks++;
        if (in_ready !== er) begin
            failures++;
            $display("FAIL in_ready got=%b exp=%b t=%0t",
                     in_ready, er, $time);
        end
        @(posedge clk);
        if (eg >= 0) begin
            if (clr_ch[eg]) hq[eg].delete();
            s = int'(d[eg]);
            foreach (hq[eg][j]) s += hq[eg][j];
            m_osum = s;
            m_och  = eg;
            m_ov   = 1'b1;
            m_last = eg;
            hq[eg].push_front(int'(d[eg]));
            if (hq[eg].size() > 3) void'(hq[eg].pop_back());
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        for (int i = 0; i < NCH; i++) begin
            if (clr_ch[i] && i != eg) hq[i].delete();
        end
        #1;
        es = (W+2)'(m_osum);
        checks++;
        if (out_valid !== m_ov) begin
            failures++;
            $display("FAIL out_valid got=%b exp=%b t=%0t",
                     out_valid, m_ov, $time);
        end
        checks++;
        if (out_ch !== CW'(m_och)) begin
            failures++;
            $display("FAIL out_ch got=%0d exp=%0d t=%0t",
                     out_ch, m_och, $time);
        end
        checks++;
        if (out_sum !== es) begin
            failures++;
            $display("FAIL out_sum got=%0d exp=%0d t=%0t",
                     out_sum, es, $time);
        end
        checks++;
        if (out_avg !== es[W+1:2]) begin
            failures++;
            $display("FAIL out_avg got=%0d exp=%0d t=%0t",
                     out_avg, es[W+1:2], $time);
        end
        g = eg;
    endtask

    task automatic idle_inputs();
        in_valid  = '0;
        clr_ch    = '0;
        en        = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        en        = 1'b1;
        out_ready = 1'b1;
        in_valid  = '1;
        for (int i = 0; i < NCH; i++) d[i] = W'($urandom);
        #12;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out_ch !== '0) begin
            failures++;
            $display("FAIL rst_out_ch got=%0d exp=0", out_ch);
        end
        checks++;
        if (out_sum !== '0) begin
            failures++;
            $display("FAIL rst_out_sum got=%0d exp=0", out_sum);
        end
        checks++;
        if (out_avg !== '0) begin
            failures++;
            $display("FAIL rst_out_avg got=%0d exp=0", out_avg);
        end
        checks++;
        if (in_ready !== '0) begin
            failures++;
            $display("FAIL rst_in_ready got=%b exp=0", in_ready);
        end
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_ch0_seq();
        int exp_sum [4] = '{4, 12, 24, 40};
        int exp_avg [4] = '{1, 3, 6, 10};
        int g;
        idle_inputs();
        in_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            d[0] = W'(4 * (k + 1));
            cycle(g);
            checks++;
            if (out_sum !== (W+2)'(exp_sum[k])) begin
                failures++;
                $display("FAIL ch0_sum[%0d] got=%0d exp=%0d",
                         k, out_sum, exp_sum[k]);
            end
            checks++;
            if (out_avg !== W'(exp_avg[k])) begin
                failures++;
                $display("FAIL ch0_avg[%0d] got=%0d exp=%0d",
                         k, out_avg, exp_avg[k]);
            end
        end
        in_valid = '0;
    endtask

    task automatic test_round_robin();
        int g;
        int start;
        idle_inputs();
        in_valid = '1;
        start = (m_last + 1) % NCH;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < NCH; i++) d[i] = W'($urandom);
            cycle(g);
            checks++;
            if (out_ch !== CW'((start + k) % NCH)) begin
                failures++;
                $display("FAIL rr_order[%0d] got=%0d exp=%0d",
                         k, out_ch, (start + k) % NCH);
            end
        end
        in_valid = '0;
    endtask

    task automatic test_max();
        int g;
        idle_inputs();
        clr_ch = 4'b0010;
        cycle(g);
        clr_ch   = '0;
        in_valid = 4'b0010;
        d[1]     = 16'hFFFF;
        for (int k = 0; k < 4; k++) cycle(g);
        checks++;
        if (out_sum !== 18'h3FFFC) begin
            failures++;
            $display("FAIL max_sum got=%h exp=3fffc", out_sum);
        end
        checks++;
        if (out_avg !== 16'hFFFF) begin
            failures++;
            $display("FAIL max_avg got=%h exp=ffff", out_avg);
        end
        in_valid = '0;
    endtask

    task automatic test_stall();
        int g;
        int hs;
        int hc;
        idle_inputs();
        in_valid = '1;
        for (int i = 0; i < NCH; i++) d[i] = W'($urandom);
        cycle(g);
        hs = m_osum;
        hc = m_och;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < NCH; i++) d[i] = W'($urandom);
            cycle(g);
            checks++;
            if (out_sum !== (W+2)'(hs) || out_ch !== CW'(hc)
                || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold[%0d] got=%0d/%0d exp=%0d/%0d",
                         k, out_sum, out_ch, hs, hc);
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NCH; i++) d[i] = W'($urandom);
            cycle(g);
        end
        in_valid = '0;
        cycle(g);
    endtask

    task automatic test_clr();
        int g;
        idle_inputs();
        clr_ch = 4'b0100;
        cycle(g);
        clr_ch   = '0;
        in_valid = 4'b0100;
        d[2]     = W'(9);
        for (int k = 0; k < 3; k++) cycle(g);
        checks++;
        if (out_sum !== (W+2)'(27)) begin
            failures++;
            $display("FAIL clr_fill got=%0d exp=27", out_sum);
        end
        clr_ch = 4'b0100;
        d[2]   = W'(5);
        cycle(g);
        checks++;
        if (out_sum !== (W+2)'(5)) begin
            failures++;
            $display("FAIL clr_accept got=%0d exp=5", out_sum);
        end
        clr_ch = '0;
        cycle(g);
        checks++;
        if (out_sum !== (W+2)'(10)) begin
            failures++;
            $display("FAIL clr_next got=%0d exp=10", out_sum);
        end
        in_valid = '0;
    endtask

    task automatic test_random();
        int g;
        for (int k = 0; k < 400; k++) begin
            in_valid  = NCH'($urandom);
            out_ready = ($urandom % 4) != 0;
            en        = ($urandom % 8) != 0;
            clr_ch    = (($urandom % 10) == 0) ? NCH'($urandom) : '0;
            for (int i = 0; i < NCH; i++) begin
                d[i] = (($urandom % 3) == 0) ? W'($urandom)
                                             : W'($urandom % 64);
            end
            cycle(g);
        end
        idle_inputs();
        cycle(g);
    endtask

    task automatic test_async_reset();
        int g;
        idle_inputs();
        in_valid = '1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NCH; i++) d[i] = W'($urandom | 1);
            cycle(g);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== '0) begin
            failures++;
            $display("FAIL arst_out got=%b/%0d exp=0/0",
                     out_valid, out_sum);
        end
        checks++;
        if (in_ready !== '0) begin
            failures++;
            $display("FAIL arst_in_ready got=%b exp=0", in_ready);
        end
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        in_valid = '1;
        for (int i = 0; i < NCH; i++) d[i] = W'($urandom);
        cycle(g);
        checks++;
        if (out_ch !== '0 || out_sum !== {2'b00, d[0]}) begin
            failures++;
            $display("FAIL arst_restart got=%0d/%0d exp=0/%0d",
                     out_ch, out_sum, d[0]);
        end
        in_valid = '0;
        cycle(g);
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) d[i] = '0;
        model_reset();
        test_reset();
        test_ch0_seq();
        test_round_robin();
        test_max();
        test_stall();
        test_clr();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
